// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle radix-2 restoring divider with its control FSM.
// It serves signed and unsigned DIV/MOD for the execute stage. It holds the
// pipeline through stallreq_o until a result is ready. A flush on cancel_i
// drops the operation in flight.
//
// Ports
//   clk          clock
//   rst          asynchronous reset, active-low
//   start_i      a DIV/MOD op is waiting in EX (held until ready_o)
//   signed_i     1 = signed operands, 0 = unsigned (sampled at accept)
//   dividend_i   reg1 operand (sampled at accept)
//   divisor_i    reg2 operand (sampled at accept)
//   cancel_i     pipeline flush; aborts any operation
//   stallreq_o   stall request to pipeline control
//   busy_o       FSM not idle
//   ready_o      quotient_o/remainder_o valid this cycle
//   quotient_o   registered quotient
//   remainder_o  registered remainder
//   div_zero_o   last result came from a zero divisor
//
// Optional feature: define DIV_EARLY_OUT_EN to finish immediately with q=0,
// r=dividend whenever |divisor| > |dividend|.
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             cancel_i,
  output logic             stallreq_o,
  output logic             busy_o,
  output logic             ready_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_zero_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_DIVZERO, S_ON, S_END} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;

  // Working registers: the dividend shifts out of dvd_q MSB-first, and the
  // quotient bits shift into it from the LSB end.
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] orig_q;
  logic             q_neg;
  logic             r_neg;

  logic             sa, sb;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic             accept, dvs_zero, early;
  logic [WIDTH:0]   trial;
  logic             qbit;
  logic [WIDTH-1:0] rem_step, quo_step;

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v,
                                              input logic n);
    return n ? ((~v) + ONE) : v;
  endfunction

  // Operand conditioning at accept: a sign counts only in signed mode.
  // -2^(W-1) maps to itself, which reads correctly as the unsigned magnitude.
  assign sa       = signed_i & dividend_i[WIDTH-1];
  assign sb       = signed_i & divisor_i[WIDTH-1];
  assign dvd_mag  = neg_if(dividend_i, sa);
  assign dvs_mag  = neg_if(divisor_i, sb);
  assign accept   = (state == S_IDLE) & start_i & ~cancel_i;
  assign dvs_zero = (divisor_i == '0);

`ifdef DIV_EARLY_OUT_EN
  assign early = ~dvs_zero & (dvs_mag > dvd_mag);
`else
  assign early = 1'b0;
`endif

  // One restoring step: shift in the next dividend bit, then trial-subtract.
  assign trial    = {rem_q, dvd_q[WIDTH-1]} - {1'b0, dvs_q};
  assign qbit     = ~trial[WIDTH];
  assign rem_step = qbit ? trial[WIDTH-1:0] : {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
  assign quo_step = {dvd_q[WIDTH-2:0], qbit};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    busy_o     = (state != S_IDLE);
    ready_o    = (state == S_END);
    // Gated by rst so every output reads 0 while reset is held.
    stallreq_o = rst & (accept | (state == S_ON) | (state == S_DIVZERO));
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (dvs_zero)   state_nxt = S_DIVZERO;
          else if (early) state_nxt = S_END;
          else            state_nxt = S_ON;
        end
      end
      S_ON:      if (cnt == CNT_LAST) state_nxt = S_END;
      S_DIVZERO: state_nxt = S_END;
      S_END:     state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
    if (cancel_i) state_nxt = S_IDLE;
  end

  // Control and result registers; results update only on entry to END.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      quotient_o  <= '0;
      remainder_o <= '0;
      div_zero_o  <= 1'b0;
    end else begin
      cnt <= (state == S_ON && state_nxt == S_ON) ? cnt + CNT_W'(1) : '0;
      if (state_nxt == S_END && state != S_END) begin
        case (state)
          S_DIVZERO: begin
            quotient_o  <= '1;
            remainder_o <= orig_q;
            div_zero_o  <= 1'b1;
          end
          S_ON: begin
            quotient_o  <= neg_if(quo_step, q_neg);
            remainder_o <= neg_if(rem_step, r_neg);
            div_zero_o  <= 1'b0;
          end
          default: begin
            quotient_o  <= '0;
            remainder_o <= dividend_i;
            div_zero_o  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Datapath registers: no reset; they are always loaded at accept before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      dvd_q  <= dvd_mag;
      dvs_q  <= dvs_mag;
      rem_q  <= '0;
      orig_q <= dividend_i;
      q_neg  <= sa ^ sb;
      r_neg  <= sa;
    end else if (state == S_ON) begin
      dvd_q  <= quo_step;
      rem_q  <= rem_step;
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, signed_i, cancel_i;
  logic [31:0] dividend_i, divisor_i;
  logic        stallreq_o, busy_o, ready_o, div_zero_o;
  logic [31:0] quotient_o, remainder_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] last_q, last_r;
  logic        last_dz;

  div_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .signed_i(signed_i),
    .dividend_i(dividend_i), .divisor_i(divisor_i), .cancel_i(cancel_i),
    .stallreq_o(stallreq_o), .busy_o(busy_o), .ready_o(ready_o),
    .quotient_o(quotient_o), .remainder_o(remainder_o), .div_zero_o(div_zero_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic (truncating division), plus latency rules.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic dz, output int lat);
    longint va, vb, aa, ab;
    va = sgn ? longint'($signed(a)) : longint'({32'b0, a});
    vb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
    aa = (va < 0) ? -va : va;
    ab = (vb < 0) ? -vb : vb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; dz = 1'b1; lat = 2;
    end else begin
      q = 32'(va / vb); r = 32'(va % vb); dz = 1'b0; lat = 33;
`ifdef DIV_EARLY_OUT_EN
      if (ab > aa) lat = 1;
`else
      if (ab > aa) lat = 33;
`endif
    end
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    start_i = 1'b1; signed_i = sgn; dividend_i = a; divisor_i = b;
  endtask

  // Called in the cycle the op is first presented (cycle 0).
  task automatic finish_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic sgn);
    logic [31:0] eq, er;
    logic        edz;
    int          lat, cyc, stalls;
    bit          done;
    model(a, b, sgn, eq, er, edz, lat);
    cyc = 0; stalls = 0; done = 0;
    while (!done) begin
      #1;
      if (ready_o) begin
        check({tag, " latency"}, cyc, lat);
        check({tag, " stall_cycles"}, stalls, cyc);
        check({tag, " stall_at_ready"}, {31'b0, stallreq_o}, 32'd0);
        check({tag, " busy_at_ready"}, {31'b0, busy_o}, 32'd1);
        check({tag, " quotient"}, quotient_o, eq);
        check({tag, " remainder"}, remainder_o, er);
        check({tag, " div_zero"}, {31'b0, div_zero_o}, {31'b0, edz});
        last_q = eq; last_r = er; last_dz = edz;
        start_i = 1'b0;
        done = 1;
      end else begin
        if (stallreq_o) stalls++;
        if (cyc >= 40) begin
          check({tag, " timeout"}, cyc, lat);
          start_i = 1'b0;
          done = 1;
        end else begin
          @(negedge clk);
          cyc++;
          if (cyc == 1) begin
            dividend_i = $urandom;
            divisor_i  = $urandom;
          end
        end
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sgn);
    @(negedge clk);
    issue(a, b, sgn);
    finish_op(tag, a, b, sgn);
  endtask

  initial begin
    logic [31:0] ra, rb;
    rst = 1'b0; start_i = 1'b0; signed_i = 1'b0; cancel_i = 1'b0;
    dividend_i = '0; divisor_i = '0;
    last_q = '0; last_r = '0; last_dz = 1'b0;
    repeat (2) @(negedge clk);
    check("rst quotient", quotient_o, 32'd0);
    check("rst remainder", remainder_o, 32'd0);
    check("rst flags", {28'b0, stallreq_o, busy_o, ready_o, div_zero_o}, 32'd0);
    rst = 1'b1;

    run_op("u100/7", 32'd100, 32'd7, 1'b0);
    run_op("s-7/2", 32'hFFFF_FFF9, 32'd2, 1'b1);
    run_op("u-7/2", 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op("u5/0", 32'd5, 32'd0, 1'b0);
    run_op("s5/0", 32'd5, 32'd0, 1'b1);
    run_op("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_op("u3/10", 32'd3, 32'd10, 1'b0);
    run_op("u100/7b", 32'd100, 32'd7, 1'b0);

    // Flush in cycle 10 of an operation, new op accepted in cycle 11.
    @(negedge clk);
    issue(32'd1000, 32'd3, 1'b0);
    for (int c = 1; c <= 10; c++) @(negedge clk);
    cancel_i = 1'b1;
    @(negedge clk);
    cancel_i = 1'b0;
    check("cancel busy", {31'b0, busy_o}, 32'd0);
    check("cancel ready", {31'b0, ready_o}, 32'd0);
    check("cancel q_hold", quotient_o, last_q);
    check("cancel r_hold", remainder_o, last_r);
    issue(32'd77, 32'd5, 1'b0);
    finish_op("after_cancel", 32'd77, 32'd5, 1'b0);

    // Async reset in the middle of an operation.
    @(negedge clk);
    issue(32'd9, 32'd2, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst quotient", quotient_o, 32'd0);
    check("midrst remainder", remainder_o, 32'd0);
    check("midrst flags", {28'b0, stallreq_o, busy_o, ready_o, div_zero_o}, 32'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: begin ra = $urandom; rb = $urandom; end
        1: begin ra = $urandom; rb = 32'($urandom_range(1, 15)); end
        2: begin ra = $urandom; rb = 32'd0; end
        3: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        4: begin ra = 32'($urandom_range(0, 100)); rb = $urandom; end
        default: begin ra = $urandom; rb = ~32'($urandom_range(0, 8)); end
      endcase
      run_op($sformatf("rnd%0d", i), ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
